// File: rtl/serial_adder_4b.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first; result valid WIDTH cycles after accept.
// Valid/ready on both ports; only accepts in IDLE, and DONE holds {carry,sum} until out_ready.
module serial_adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_s_sr;
    logic               r_c_ff;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_s_nxt;
    logic               w_last;

    assign w_s     = r_a_sr[0] ^ r_b_sr[0] ^ r_c_ff;
    assign w_c     = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_c_ff) | (r_b_sr[0] & r_c_ff);
    // New sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
    assign w_s_nxt = (r_s_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
    assign w_last  = (r_cnt == LAST);

    assign sum     = r_sum;
    assign carry   = r_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = CALC;
            end
            CALC: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_c_ff  <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_c_ff <= cin;
                        r_s_sr <= '0;
                        r_cnt  <= '0;
                    end
                end
                CALC: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_c_ff <= w_c;
                    r_s_sr <= w_s_nxt;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // Outputs only ever see a complete result.
                    if (w_last) begin
                        r_sum   <= w_s_nxt;
                        r_carry <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_4b.md
# serial_adder_4b

Bit-serial, handshake-driven counterpart to the combinational 4-bit full adder. It accepts an operand pair plus carry-in through a valid/ready input port and computes one sum bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It returns {carry, sum} through a valid/ready output port. It is the clocked DUT that the team's stimulus/check pattern drives when exercising handshake-based arithmetic.

## Interface
- WIDTH, 4, operand and sum width in bits (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- out_valid  output  1  {carry, sum} holds a completed result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH
- carry  output  1  registered carry-out, bit WIDTH of a+b+cin

## Operation
- The FSM has three states: IDLE, CALC, DONE. Reset enters IDLE.
- Reset values: in_ready=1, out_valid=0, sum=0, carry=0. Internal shift registers, counter and carry flip-flop are all 0.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at a rising edge, capture a, b, cin into shift registers A_sr, B_sr, C_ff and clear the bit counter.
  - Next state is CALC.
- CALC:
  - in_ready=0.
  - Each edge: s=A_sr[0]^B_sr[0]^C_ff; C_ff<=majority(A_sr[0],B_sr[0],C_ff).
  - A_sr and B_sr shift right. s shifts into S_sr from the MSB side. The counter increments.
  - When the counter reaches WIDTH-1 at an edge, that same edge loads sum<=final S_sr value and carry<=final carry, then moves to DONE.
- DONE:
  - out_valid=1. sum and carry are stable.
  - When out_valid&&out_ready at an edge, the next state is IDLE and out_valid drops.
- sum and carry keep the last result after the handshake until the next completion overwrites them. They never show partial results.
- Arithmetic is unsigned. {carry,sum} equals a+b+cin with width WIDTH+1, and no overflow is possible.
- in_valid while in_ready=0 is ignored. The a, b and cin values at that time have no effect.

## Timing
- Acceptance edge E0. The result is computed over edges E1..EW. out_valid is high from immediately after edge EW, giving a latency of WIDTH cycles from acceptance.
- Earliest new acceptance is the edge after the output handshake. With out_ready held high, the minimum period is WIDTH+2 cycles per operation (6 for WIDTH=4).
- Simultaneous events:
  - In DONE, in_valid is ignored because in_ready=0. No result is overwritten.
  - out_ready asserted in IDLE or CALC has no effect.
- Backpressure: DONE holds indefinitely while out_ready=0. sum, carry and out_valid do not change.
- Reset mid-operation, asynchronous in any state:
  - The operation is abandoned with no result.
  - All outputs immediately take their reset values.
  - After release, the FSM is in IDLE with in_ready=1.
- in_ready and out_valid are direct decodes of registered state and have no combinational path from inputs.

## Test plan
- Carry case: a=7, b=8, cin=1 with out_ready=1 → out_valid rises 4 cycles after acceptance; sum=0, carry=1; in_ready returns to 1 one cycle after the handshake.
- Extremes: a=15, b=15, cin=1 → sum=15, carry=1. Then a=0, b=0, cin=0 → sum=0, carry=0. Results stay stable after the handshake until the next completion.
- Backpressure: a=9, b=5, cin=0 with out_ready=0 for 5 cycles after out_valid → out_valid stays 1 and sum=14, carry=0 stay stable; a new in_valid with a=1 during DONE is ignored. On out_ready=1, handshake completes and the state goes to IDLE.
- Busy rejection: in_valid held high with changing a/b during CALC → only the operands captured at E0 affect the result, e.g. a=3, b=4, cin=0 gives sum=7.
- Reset mid-CALC: assert rst at counter=2 → out_valid=0, sum=0, carry=0 and in_ready=1 immediately. After release, a=1, b=1, cin=1 gives sum=3, carry=0.
- Random: 1000 operations with random a, b, cin and random out_ready stalls → every {carry,sum} equals a+b+cin, and no result is lost or duplicated.
